// File: rtl/dr_pkg.sv
// dr_pkg: shared types and sizing helpers for the DR commit queue.
//   DATA_W / COL_W : default prediction and column widths.
//   dr_entry_t     : one buffered {pred, col} pair at default widths.
//   ptr_w(depth)   : pointer width, one bit wider than the slot index so
//                    that full and empty can be told apart.
package dr_pkg;
  localparam int DATA_W = 32;
  localparam int COL_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] pred;
    logic [COL_W-1:0]  col;
  } dr_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/dr_commit_queue_if.sv
// dr_commit_queue_if: handshake bundle between the inspector, the commit
// queue and the downstream consumer.
//   master : inspector/consumer side (drives in_*, flush, commit_ready)
//   slave  : commit queue side (drives in_ready, commit_*, replay_*, squash_cnt)
interface dr_commit_queue_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = dr_pkg::DATA_W,
  parameter int COL_W  = dr_pkg::COL_W
);
  import dr_pkg::*;
  localparam int PW = ptr_w(DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pred;
  logic [COL_W-1:0]  in_col;
  logic              flush;
  logic              commit_valid;
  logic              commit_ready;
  logic [DATA_W-1:0] commit_pred;
  logic [COL_W-1:0]  commit_col;
  logic              replay_valid;
  logic [COL_W-1:0]  replay_col;
  logic [PW-1:0]     squash_cnt;

  modport master (
    output in_valid, in_pred, in_col, flush, commit_ready,
    input  in_ready, commit_valid, commit_pred, commit_col,
           replay_valid, replay_col, squash_cnt
  );

  modport slave (
    input  in_valid, in_pred, in_col, flush, commit_ready,
    output in_ready, commit_valid, commit_pred, commit_col,
           replay_valid, replay_col, squash_cnt
  );
endinterface

// File: rtl/dr_age_tracker.sv
// dr_age_tracker: per-slot saturating age counters and the decision to
// advance the confirm pointer by one slot this cycle.
//   clk, rst     : clock, async active-high reset
//   push         : an entry is written this cycle at push_idx (age -> 0)
//   conf_idx     : slot index of the confirm pointer
//   conf_pending : at least one speculative entry exists (conf != wr)
//   adv          : oldest speculative entry has aged out; confirm it
// CONFIRM_LAT must be >= 1.
module dr_age_tracker #(
  parameter int DEPTH       = 8,
  parameter int CONFIRM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [$clog2(DEPTH)-1:0] push_idx,
  input  logic [$clog2(DEPTH)-1:0] conf_idx,
  input  logic                     conf_pending,
  output logic                     adv
);
  localparam int IW = $clog2(DEPTH);
  localparam int AW = $clog2(CONFIRM_LAT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(CONFIRM_LAT);

  logic [AW-1:0] age [DEPTH];

  // Every slot ages, not only the speculative ones: a slot's age is only
  // ever consulted while it sits at conf, and a push always restarts it,
  // so ages of free or confirmed slots are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && push_idx == IW'(i)) age[i] <= '0;
        else if (age[i] != AGE_MAX)     age[i] <= age[i] + 1'b1;
      end
    end
  end

  assign adv = conf_pending && (age[conf_idx] >= AGE_MAX);
endmodule

// File: rtl/dr_commit_queue.sv
// dr_commit_queue: speculative commit buffer behind the DR inspector.
// Entries age for CONFIRM_LAT cycles before they become confirmed; a flush
// squashes all still-speculative entries and pulses a replay request for
// the oldest squashed column. Confirmed entries drain via commit_valid/ready.
//   clk, rst : clock, async active-high reset
//   bus      : dr_commit_queue_if.slave (in_*, flush, commit_*, replay_*,
//              squash_cnt)
// Optional: define DR_COMMIT_STATS_EN to add 32-bit stat_commits and
// stat_squashed counters.
module dr_commit_queue #(
  parameter int DEPTH       = 8,
  parameter int CONFIRM_LAT = 2,
  parameter int DATA_W      = dr_pkg::DATA_W,
  parameter int COL_W       = dr_pkg::COL_W
) (
  input  logic               clk,
  input  logic               rst,
  dr_commit_queue_if.slave   bus
`ifdef DR_COMMIT_STATS_EN
  ,
  output logic [31:0]        stat_commits,
  output logic [31:0]        stat_squashed
`endif
);
  import dr_pkg::*;
  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  typedef struct packed {
    logic [DATA_W-1:0] pred;
    logic [COL_W-1:0]  col;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd, conf, wr;
  logic [PW-1:0] conf_nx, squash_nx, count;
  logic          adv, push, pop;
  logic          replay_valid_q;
  logic [COL_W-1:0] replay_col_q;
  logic [PW-1:0] squash_cnt_q;

  // Registered-only full test: a same-cycle commit never reopens in_ready.
  assign count            = wr - rd;
  assign bus.in_ready     = (count < PW'(DEPTH));
  assign bus.commit_valid = (rd != conf);
  assign bus.commit_pred  = mem[rd[IW-1:0]].pred;
  assign bus.commit_col   = mem[rd[IW-1:0]].col;
  assign bus.replay_valid = replay_valid_q;
  assign bus.replay_col   = replay_col_q;
  assign bus.squash_cnt   = squash_cnt_q;

  assign push      = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop       = bus.commit_valid && bus.commit_ready;
  // Confirmation is folded in before the flush cut, so an entry aging out
  // in the flush cycle survives.
  assign conf_nx   = conf + PW'(adv);
  assign squash_nx = wr - conf_nx;

  dr_age_tracker #(.DEPTH(DEPTH), .CONFIRM_LAT(CONFIRM_LAT)) u_age (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_idx     (wr[IW-1:0]),
    .conf_idx     (conf[IW-1:0]),
    .conf_pending (conf != wr),
    .adv          (adv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd             <= '0;
      conf           <= '0;
      wr             <= '0;
      replay_valid_q <= 1'b0;
      replay_col_q   <= '0;
      squash_cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rd             <= rd + PW'(pop);
      conf           <= conf_nx;
      replay_valid_q <= 1'b0;
      if (bus.flush) begin
        wr           <= conf_nx;
        squash_cnt_q <= squash_nx;
        if (squash_nx != '0) begin
          replay_valid_q <= 1'b1;
          replay_col_q   <= mem[conf_nx[IW-1:0]].col;
        end
      end else if (push) begin
        wr                <= wr + PW'(1);
        mem[wr[IW-1:0]]   <= '{pred: bus.in_pred, col: bus.in_col};
      end
    end
  end

`ifdef DR_COMMIT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_commits  <= '0;
      stat_squashed <= '0;
    end else begin
      if (pop)       stat_commits  <= stat_commits + 32'd1;
      if (bus.flush) stat_squashed <= stat_squashed + 32'(squash_nx);
    end
  end
`endif
endmodule
